// File: rtl/tex_qspi_pkg.sv
// Shared constants and state encoding for the texture QSPI fetch path.
package tex_qspi_pkg;

    localparam logic [7:0]  TEX_CMD_QREAD = 8'h6B;
    localparam int unsigned TEX_CMD_BITS  = 8;
    localparam int unsigned TEX_ADDR_BITS = 24;
    localparam int unsigned TEX_CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5,
        GAP   = 3'd6
    } tex_state_e;

endpackage

// File: rtl/tex_rr_arb2.sv
// Two-way round-robin grant logic; last_grant advances only when the grant is taken.
module tex_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last_grant;

    // Lone request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        gnt_idx = 1'b0;
        gnt     = 2'b00;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
        if (req != 2'b00) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Remember the most recent grantee for tie-breaking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/tex_qspi_fetch_arb.sv
// Quad-output (0x6B) flash reader shared between the wall and overlay texture requesters.
module tex_qspi_fetch_arb
    import tex_qspi_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 24,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned CSB_GAP      = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_req0,
    input  logic [23:0]          i_addr0,
    output logic                 o_ack0,
    input  logic                 i_req1,
    input  logic [23:0]          i_addr1,
    output logic                 o_ack1,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_busy,
    output logic                 o_tex_csb,
    output logic                 o_tex_sclk,
    output logic                 o_tex_oeb0,
    output logic                 o_tex_out0,
    input  logic [3:0]           i_tex_in
);

    localparam int unsigned NIBBLES = DATA_BITS / 4;
    localparam int unsigned TX_W    = TEX_CMD_BITS + TEX_ADDR_BITS;
    localparam int unsigned GAP_W   = 8;

    tex_state_e              state_q, state_d;
    logic                    phase_q, phase_d;
    logic [TEX_CNT_W-1:0]    cnt_q, cnt_d;
    logic [TX_W-1:0]         tx_q, tx_d;
    logic [DATA_BITS-1:0]    rx_q, rx_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    grantee_q, grantee_d;
    logic                    csb_q, csb_d;
    logic                    sclk_q, sclk_d;
    logic                    oeb0_q, oeb0_d;
    logic                    out0_q, out0_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic [1:0]              gnt;
    logic                    gnt_idx;

    tex_rr_arb2 u_arb (
        .clk     (i_clk),
        .rst_n   (i_reset_n),
        .req     ({i_req1, i_req0}),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Next-state and next-output logic; every pin value is registered below.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;
        gap_d     = gap_q;
        grantee_d = grantee_q;
        csb_d     = csb_q;
        sclk_d    = 1'b0;
        oeb0_d    = oeb0_q;
        out0_d    = out0_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gap_q == '0 && gnt != 2'b00) begin
                    accept    = 1'b1;
                    grantee_d = gnt_idx;
                    tx_d      = {TEX_CMD_QREAD, gnt[1] ? i_addr1 : i_addr0};
                    out0_d    = TEX_CMD_QREAD[7];
                    oeb0_d    = 1'b0;
                    csb_d     = 1'b0;
                    phase_d   = 1'b0;
                    cnt_d     = TEX_CNT_W'(TEX_CMD_BITS - 1);
                    state_d   = CMD;
                end
            end

            CMD, ADDR, DUMMY, DATA: begin
                if (!phase_q) begin
                    // Phase A -> B: raise sclk, flash sees a stable bit.
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    // End of phase B: sample input, advance output bit.
                    phase_d = 1'b0;
                    if (state_q == DATA) begin
                        rx_d = DATA_BITS'({rx_q, i_tex_in});
                    end
                    if (state_q == CMD || state_q == ADDR) begin
                        tx_d   = tx_q << 1;
                        out0_d = tx_q[TX_W-2];
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TEX_CNT_W'(1);
                    end else begin
                        case (state_q)
                            CMD: begin
                                state_d = ADDR;
                                cnt_d   = TEX_CNT_W'(TEX_ADDR_BITS - 1);
                            end
                            ADDR: begin
                                // Release io0 so the flash can drive it.
                                state_d = DUMMY;
                                cnt_d   = TEX_CNT_W'(DUMMY_CYCLES - 1);
                                oeb0_d  = 1'b1;
                                out0_d  = 1'b0;
                            end
                            DUMMY: begin
                                state_d = DATA;
                                cnt_d   = TEX_CNT_W'(NIBBLES - 1);
                            end
                            default: begin
                                state_d = DONE;
                                csb_d   = 1'b1;
                            end
                        endcase
                    end
                end
            end

            DONE: begin
                data_d  = rx_q;
                ack0_d  = ~grantee_q;
                ack1_d  = grantee_q;
                gap_d   = GAP_W'(CSB_GAP - 1);
                state_d = GAP;
            end

            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset parks the pads idle and drops any transfer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            gap_q     <= '0;
            grantee_q <= 1'b0;
            csb_q     <= 1'b1;
            sclk_q    <= 1'b0;
            oeb0_q    <= 1'b1;
            out0_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            gap_q     <= gap_d;
            grantee_q <= grantee_d;
            csb_q     <= csb_d;
            sclk_q    <= sclk_d;
            oeb0_q    <= oeb0_d;
            out0_q    <= out0_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
        end
    end

    assign o_ack0     = ack0_q;
    assign o_ack1     = ack1_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_tex_csb  = csb_q;
    assign o_tex_sclk = sclk_q;
    assign o_tex_oeb0 = oeb0_q;
    assign o_tex_out0 = out0_q;

endmodule

// File: tb/tb_tex_qspi_fetch_arb.sv
// Scoreboard bench: a default-parameter reader and an 8-bit/4-dummy reader, each with a flash model.
module tb_tex_qspi_fetch_arb;

    localparam int CSB_GAP = 2;

    typedef struct packed {
        logic        who;
        logic [23:0] addr;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic        ack0, ack1, busy, tex_csb, tex_sclk, oeb0, out0;
    logic [23:0] data;
    logic [3:0]  tex_in = '0;

    logic        sw_req0 = 1'b0, sw_req1 = 1'b0;
    logic [23:0] sw_addr0 = '0, sw_addr1 = '0;
    logic        sw_ack0, sw_ack1, sw_busy, sw_csb, sw_sclk, sw_oeb0, sw_out0;
    logic [7:0]  sw_data;
    logic [3:0]  sw_tex_in = '0;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t sb_s[$];
    bit   spacing_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tex_qspi_fetch_arb dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0(req0), .i_addr0(addr0), .o_ack0(ack0),
        .i_req1(req1), .i_addr1(addr1), .o_ack1(ack1),
        .o_data(data), .o_busy(busy),
        .o_tex_csb(tex_csb), .o_tex_sclk(tex_sclk),
        .o_tex_oeb0(oeb0), .o_tex_out0(out0), .i_tex_in(tex_in)
    );

    tex_qspi_fetch_arb #(.DATA_BITS(8), .DUMMY_CYCLES(4), .CSB_GAP(2)) dut_s (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req0(sw_req0), .i_addr0(sw_addr0), .o_ack0(sw_ack0),
        .i_req1(sw_req1), .i_addr1(sw_addr1), .o_ack1(sw_ack1),
        .o_data(sw_data), .o_busy(sw_busy),
        .o_tex_csb(sw_csb), .o_tex_sclk(sw_sclk),
        .o_tex_oeb0(sw_oeb0), .o_tex_out0(sw_out0), .i_tex_in(sw_tex_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flash contents: one known word for the reference read, an address hash elsewhere.
    function automatic logic [23:0] flash_word(input logic [23:0] a);
        if (a == 24'h012345) return 24'hA5C3F0;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3, a[23:16] ^ 8'h96};
    endfunction

    function automatic logic [3:0] nib(input logic [23:0] a, input int k);
        logic [23:0] w;
        w = flash_word(a);
        return w[23-4*k -: 4];
    endfunction

    task automatic push_m(input logic who, input logic [23:0] a);
        exp_t e;
        e.who = who; e.addr = a; e.data = flash_word(a);
        sb.push_back(e);
    endtask

    task automatic push_s(input logic who, input logic [23:0] a);
        exp_t        e;
        logic [23:0] w;
        w = flash_word(a);
        e.who = who; e.addr = a; e.data = {16'h0, w[23:16]};
        sb_s.push_back(e);
    endtask

    // Flash model for the default reader: capture cmd/addr, then present data nibbles.
    int          fm_cnt = 0;
    logic [31:0] fm_sh = '0;
    always @(negedge tex_csb or posedge tex_csb or posedge tex_sclk) begin
        if (tex_csb === 1'b1) begin
            if (rst_n === 1'b1 && sb.size() > 0 && fm_cnt >= 32) begin
                chk("cmd_byte", 32'(fm_sh[31:24]), 32'h6B);
                chk("addr_bits", 32'(fm_sh[23:0]), 32'(sb[0].addr));
            end
        end else if (tex_sclk === 1'b0) begin
            fm_cnt = 0;
            fm_sh  = '0;
        end else begin
            if (fm_cnt == 0)  chk("oeb_cmd", 32'(oeb0), 32'd0);
            if (fm_cnt == 32) chk("oeb_dummy", 32'(oeb0), 32'd1);
            if (fm_cnt < 32) fm_sh = {fm_sh[30:0], out0};
            if (fm_cnt >= 40 && fm_cnt < 46) tex_in = nib(fm_sh[23:0], fm_cnt - 40);
            fm_cnt++;
        end
    end

    // Flash model for the 8-bit / 4-dummy reader.
    int          fs_cnt = 0;
    logic [31:0] fs_sh = '0;
    always @(negedge sw_csb or posedge sw_sclk) begin
        if (sw_csb === 1'b0 && sw_sclk === 1'b0) begin
            fs_cnt = 0;
            fs_sh  = '0;
        end else if (sw_csb === 1'b0) begin
            if (fs_cnt < 32) fs_sh = {fs_sh[30:0], sw_out0};
            if (fs_cnt >= 36 && fs_cnt < 38) sw_tex_in = nib(fs_sh[23:0], fs_cnt - 36);
            fs_cnt++;
        end
    end

    // Monitor for the default reader: framing, latency, spacing and scoreboard pops.
    int   acc_edge = 0, rise_edge = -1, last_ack = -1;
    bit   in_txn = 1'b0, prev_csb = 1'b1, prev_ack = 1'b0;
    exp_t em;
    always @(negedge clk) begin
        if (!spacing_on) last_ack = -1;
        if (rst_n !== 1'b1) begin
            in_txn = 1'b0; prev_csb = 1'b1; rise_edge = -1; prev_ack = 1'b0;
        end else begin
            if (prev_csb && !tex_csb) begin
                if (rise_edge >= 0) chk("csb_gap", 32'((cyc - rise_edge) >= CSB_GAP), 32'd1);
                chk("busy_on_accept", 32'(busy), 32'd1);
                acc_edge = cyc;
                in_txn   = 1'b1;
            end
            if (!prev_csb && tex_csb && in_txn) begin
                chk("csb_low_len", 32'(cyc - acc_edge), 32'd92);
                rise_edge = cyc;
                in_txn    = 1'b0;
            end
            if (prev_ack) chk("ack_pulse", 32'(ack0 | ack1), 32'd0);
            if (ack0 | ack1) begin
                chk("ack_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    em = sb.pop_front();
                    chk("ack_who", 32'(ack1), 32'(em.who));
                    chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
                    chk("read_data", 32'(data), 32'(em.data));
                    chk("ack_latency", 32'(cyc - acc_edge), 32'd93);
                    if (spacing_on && last_ack >= 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd95);
                end
                last_ack = cyc;
            end
            prev_ack = ack0 | ack1;
            prev_csb = tex_csb;
        end
    end

    // Monitor for the swept reader.
    int   acc_s = 0;
    bit   prev_csb_s = 1'b1;
    exp_t es;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_csb_s = 1'b1;
        end else begin
            if (prev_csb_s && !sw_csb) acc_s = cyc;
            if (sw_ack0 | sw_ack1) begin
                chk("sw_ack_expected", 32'(sb_s.size() != 0), 32'd1);
                if (sb_s.size() != 0) begin
                    es = sb_s.pop_front();
                    chk("sw_ack_who", 32'(sw_ack1), 32'(es.who));
                    chk("sw_data", 32'(sw_data), 32'(es.data));
                    chk("sw_ack_latency", 32'(cyc - acc_s), 32'd77);
                end
            end
            prev_csb_s = sw_csb;
        end
    end

    task automatic wait_acks(input bit swept, input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (swept ? (sw_ack0 | sw_ack1) : (ack0 | ack1)) seen++;
        end
        if (seen < n) chk("ack_timeout", 32'(seen), 32'(n));
    endtask

    task automatic wait_csb_low(input int budget);
        int t = 0;
        while (tex_csb && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (tex_csb) chk("accept_timeout", 32'(tex_csb), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, during and just after reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", 32'(tex_csb), 32'd1);
        chk("rst_sclk", 32'(tex_sclk), 32'd0);
        chk("rst_oeb0", 32'(oeb0), 32'd1);
        chk("rst_out0", 32'(out0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({ack1, ack0}), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_csb", 32'(tex_csb), 32'd1);
        chk("post_rst_sclk", 32'(tex_sclk), 32'd0);
        chk("post_rst_oeb0", 32'(oeb0), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single read; address changes after acceptance must be ignored.
        push_m(1'b0, 24'h012345);
        addr0 = 24'h012345;
        req0  = 1'b1;
        wait_csb_low(20);
        addr0 = 24'hFFFFFF;
        wait_acks(1'b0, 1, 200);
        req0 = 1'b0;
        chk("single_data", 32'(data), 32'h00A5C3F0);
        repeat (6) @(negedge clk);
        chk("data_hold", 32'(data), 32'h00A5C3F0);

        // Lone requester 1 granted back-to-back.
        spacing_on = 1'b1;
        addr1 = 24'h3C0FFE;
        repeat (3) push_m(1'b1, 24'h3C0FFE);
        req1 = 1'b1;
        wait_acks(1'b0, 3, 400);
        req1 = 1'b0;
        spacing_on = 1'b0;
        repeat (6) @(negedge clk);

        // Contention: strict alternation starting with requester 0.
        spacing_on = 1'b1;
        addr0 = 24'h000100;
        addr1 = 24'h000200;
        push_m(1'b0, 24'h000100);
        push_m(1'b1, 24'h000200);
        push_m(1'b0, 24'h000100);
        push_m(1'b1, 24'h000200);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(1'b0, 4, 500);
        req0 = 1'b0;
        req1 = 1'b0;
        spacing_on = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the data phase aborts without ack or retry.
        addr0 = 24'h00ABCD;
        req0  = 1'b1;
        wait_csb_low(20);
        repeat (85) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        chk("abort_csb", 32'(tex_csb), 32'd1);
        chk("abort_sclk", 32'(tex_sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'({ack1, ack0}), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_retry_csb", 32'(tex_csb), 32'd1);
        chk("no_retry_busy", 32'(busy), 32'd0);
        push_m(1'b0, 24'h00ABCD);
        req0 = 1'b1;
        wait_acks(1'b0, 1, 200);
        req0 = 1'b0;
        repeat (6) @(negedge clk);

        // Swept parameters: 8 data bits, 4 dummy clocks.
        push_s(1'b0, 24'h012345);
        sw_addr0 = 24'h012345;
        sw_req0  = 1'b1;
        wait_acks(1'b1, 1, 200);
        sw_req0 = 1'b0;
        repeat (6) @(negedge clk);
        push_s(1'b1, 24'h00BEEF);
        sw_addr1 = 24'h00BEEF;
        sw_req1  = 1'b1;
        wait_acks(1'b1, 1, 200);
        sw_req1 = 1'b0;
        repeat (6) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("sb_s_drained", 32'(sb_s.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
